fp_norm_round: RTL and testbench



---
 rtl/fpu_pkg.sv | 29 ++
 rtl/fp_rne_round.sv | 49 ++++
 rtl/fp_norm_round.sv | 161 ++++++++++++++++
 tb/tb_fp_norm_round.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: field widths, the normaliser state encoding,
// result-flag bit positions and the packed IEEE-754 single layout.
package fpu_pkg;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned MANT_W  = 24;
  localparam int unsigned EXP_MAX = 255;
  localparam int unsigned BIAS    = 127;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } norm_state_t;

  // Bit positions inside the {overflow, underflow, inexact, zero} flag word
  localparam int unsigned FLG_OVF  = 3;
  localparam int unsigned FLG_UNF  = 2;
  localparam int unsigned FLG_INX  = 1;
  localparam int unsigned FLG_ZERO = 0;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-2:0] frac;
  } fp32_t;

endpackage

// File: rtl/fp_rne_round.sv
// Combinational round-to-nearest-even of a normalised (or denormal) mantissa.
// Ports:
//   mant_i    : mantissa including hidden bit
//   g_i/r_i/s_i : guard, round and sticky bits below the mantissa LSB
//   exp_i     : biased exponent, one bit wider than the field so it never wraps
//   mant_o    : rounded mantissa
//   exp_o     : exponent, bumped when the increment carries out of the mantissa
//   inexact_o : any discarded bit was non-zero
module fp_rne_round
  import fpu_pkg::*;
#(
  parameter int unsigned MANT_W = fpu_pkg::MANT_W,
  parameter int unsigned EXP_W  = fpu_pkg::EXP_W
) (
  input  logic [MANT_W-1:0] mant_i,
  input  logic              g_i,
  input  logic              r_i,
  input  logic              s_i,
  input  logic [EXP_W:0]    exp_i,
  output logic [MANT_W-1:0] mant_o,
  output logic [EXP_W:0]    exp_o,
  output logic              inexact_o
);

  // Above half, or exactly half with an odd LSB, rounds up
  function automatic logic rne_up(input logic lsb, input logic g,
                                  input logic r, input logic s);
    return g & (r | s | lsb);
  endfunction

  logic          up;
  logic [MANT_W:0] sum;

  assign up        = rne_up(mant_i[0], g_i, r_i, s_i);
  assign sum       = {1'b0, mant_i} + {{MANT_W{1'b0}}, up};
  assign inexact_o = g_i | r_i | s_i;

  always_comb begin
    if (sum[MANT_W]) begin
      // All-ones mantissa rolled over: renormalise to 1.0 and bump exponent
      mant_o = {1'b1, {(MANT_W-1){1'b0}}};
      exp_o  = exp_i + (EXP_W+1)'(1);
    end else begin
      mant_o = sum[MANT_W-1:0];
      exp_o  = exp_i;
    end
  end

endmodule

// File: rtl/fp_norm_round.sv
// Normalise / round / pack stage behind the 24-bit mantissa adder.
// Accepts the raw sum, carry-out and G/R/S bits, left-normalises one bit per
// cycle, rounds to nearest-even and packs an IEEE-754 single.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : upstream handshake (ready only while idle)
//   in_sign, in_exp, in_mant, in_cout, in_grs : adder result
//   out_valid/ready : downstream handshake, result held until accepted
//   out_result      : packed {sign, exp, frac}
//   out_flags       : {overflow, underflow, inexact, zero}
module fp_norm_round
  import fpu_pkg::*;
#(
  parameter int unsigned MANT_W  = fpu_pkg::MANT_W,
  parameter int unsigned EXP_W   = fpu_pkg::EXP_W,
  parameter int unsigned EXP_MAX = fpu_pkg::EXP_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic              in_cout,
  input  logic [2:0]        in_grs,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [3:0]        out_flags
);

  localparam logic [EXP_W:0] EXP_ONE = (EXP_W+1)'(1);
  localparam logic [EXP_W:0] EXP_SAT = (EXP_W+1)'(EXP_MAX);

  norm_state_t       state_q, state_d;
  logic              sign_q, sign_d;
  logic [EXP_W:0]    exp_q, exp_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic              g_q, g_d, r_q, r_d, s_q, s_d;
  logic [31:0]       res_q, res_d;
  logic [3:0]        flags_q, flags_d;

  logic              is_zero;
  logic              norm_done;
  logic [MANT_W-1:0] rnd_mant;
  logic [EXP_W:0]    rnd_exp;
  logic              rnd_inx;
  fp32_t             pk;

  assign is_zero   = (mant_q == '0) & ~(g_q | r_q | s_q);
  // Stop at hidden bit set, at the denormal floor, or on an exact zero
  assign norm_done = mant_q[MANT_W-1] | (exp_q == EXP_ONE) | is_zero;

  fp_rne_round #(.MANT_W(MANT_W), .EXP_W(EXP_W)) u_round (
    .mant_i    (mant_q),
    .g_i       (g_q),
    .r_i       (r_q),
    .s_i       (s_q),
    .exp_i     (exp_q),
    .mant_o    (rnd_mant),
    .exp_o     (rnd_exp),
    .inexact_o (rnd_inx)
  );

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    g_d     = g_q;
    r_d     = r_q;
    s_d     = s_q;
    res_d   = res_q;
    flags_d = flags_q;
    pk      = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          state_d = NORM;
          if (in_cout) begin
            // Carry-out: shift right once, old R folds into sticky
            mant_d = {1'b1, in_mant[MANT_W-1:1]};
            g_d    = in_mant[0];
            r_d    = in_grs[2];
            s_d    = in_grs[1] | in_grs[0];
            exp_d  = {1'b0, in_exp} + EXP_ONE;
          end else begin
            mant_d = in_mant;
            g_d    = in_grs[2];
            r_d    = in_grs[1];
            s_d    = in_grs[0];
            exp_d  = {1'b0, in_exp};
          end
        end
      end
      NORM: begin
        if (norm_done) begin
          state_d = ROUND;
        end else begin
          // Sticky stays put: it only records that something lies below R
          mant_d = {mant_q[MANT_W-2:0], g_q};
          g_d    = r_q;
          r_d    = 1'b0;
          exp_d  = exp_q - EXP_ONE;
        end
      end
      ROUND: begin
        pk.sign = sign_q;
        flags_d = '0;
        if (is_zero) begin
          flags_d[FLG_ZERO] = 1'b1;
        end else if (rnd_exp >= EXP_SAT) begin
          pk.exp           = '1;
          flags_d[FLG_OVF] = 1'b1;
          flags_d[FLG_INX] = 1'b1;
        end else begin
          // Hidden bit clear only happens at the denormal floor: field is 0
          pk.exp           = rnd_mant[MANT_W-1] ? rnd_exp[EXP_W-1:0] : '0;
          pk.frac          = rnd_mant[MANT_W-2:0];
          flags_d[FLG_INX] = rnd_inx;
          flags_d[FLG_UNF] = ~rnd_mant[MANT_W-1] & rnd_inx;
        end
        res_d   = pk;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    sign_q <= sign_d;
    exp_q  <= exp_d;
    mant_q <= mant_d;
    g_q    <= g_d;
    r_q    <= r_d;
    s_q    <= s_d;
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = res_q;
  assign out_flags  = flags_q;

endmodule

// File: tb/tb_fp_norm_round.sv
module tb_fp_norm_round;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = 8'h0;
  logic [23:0] in_mant = 24'h0;
  logic        in_cout = 1'b0;
  logic [2:0]  in_grs = 3'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  int nvec = 0;
  int nerr = 0;

  logic        r_s, r_c;
  logic [7:0]  r_e;
  logic [23:0] r_m;
  logic [2:0]  r_grs;
  logic [31:0] m_res;
  logic [3:0]  m_flg;
  int          m_k;

  always #5 clk = ~clk;

  fp_norm_round dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .in_cout    (in_cout),
    .in_grs     (in_grs),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Value model: the input is a 26-bit significand {mant,G,R} plus an
  // infinitesimal sticky tail. Normalisation is a single shift by the
  // leading-zero count, limited so the exponent stops at 1.
  function automatic void fp_model(input logic s, input logic [7:0] e_in,
                                   input logic [23:0] m_in, input logic c,
                                   input logic [2:0] grs,
                                   output logic [31:0] res, output logic [3:0] flg,
                                   output int k);
    logic [25:0] w;
    logic        st, g, r, inx, above, half, up;
    logic [23:0] mant;
    logic [24:0] m;
    int          e, lz;
    w  = {m_in, grs[2], grs[1]};
    st = grs[0];
    e  = int'(e_in);
    k  = 0;
    if (c) begin
      st = st | w[0];
      w  = {1'b1, w[25:1]};
      e  = e + 1;
    end
    if (w == 26'h0 && !st) begin
      res = {s, 31'h0};
      flg = 4'b0001;
      return;
    end
    lz = 100000;
    for (int i = 0; i < 26; i++) if (w[i]) lz = 25 - i;
    k = (lz < e - 1) ? lz : e - 1;
    w = w << k;
    e = e - k;
    mant  = w[25:2];
    g     = w[1];
    r     = w[0];
    above = g && (r || st);
    half  = g && !r && !st;
    up    = above || (half && mant[0]);
    inx   = g | r | st;
    m = {1'b0, mant} + {24'h0, up};
    if (m[24]) begin
      m = 25'h0800000;
      e = e + 1;
    end
    if (e >= 255) begin
      res = {s, 8'hFF, 23'h0};
      flg = 4'b1010;
    end else if (!m[23]) begin
      res = {s, 8'h00, m[22:0]};
      flg = {1'b0, inx, inx, 1'b0};
    end else begin
      res = {s, e[7:0], m[22:0]};
      flg = {2'b00, inx, 1'b0};
    end
  endfunction

  task automatic run_vec(input string tag, input logic s, input logic [7:0] e,
                         input logic [23:0] m, input logic c, input logic [2:0] grs,
                         input logic [31:0] exp_res, input logic [3:0] exp_flg,
                         input int exp_lat, input int hold);
    int cnt;
    @(negedge clk);
    check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_cout  = c;
    in_grs   = grs;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
    cnt = 0;
    while (!out_valid && cnt < 400) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check({tag, " latency"}, 32'(cnt), 32'(exp_lat));
    check({tag, " result"}, out_result, exp_res);
    check({tag, " flags"}, 32'(out_flags), 32'(exp_flg));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, " hold valid"}, 32'(out_valid), 32'd1);
      check({tag, " hold result"}, out_result, exp_res);
      check({tag, " hold flags"}, 32'(out_flags), 32'(exp_flg));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " valid drop"}, 32'(out_valid), 32'd0);
    check({tag, " ready back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_result", out_result, 32'h0);
    check("rst out_flags", 32'(out_flags), 32'd0);
    rst = 1'b0;

    run_vec("one",      1'b0, 8'h7F, 24'h800000, 1'b0, 3'b000, 32'h3F800000, 4'b0000, 2, 0);
    run_vec("cout",     1'b0, 8'h7F, 24'h000000, 1'b1, 3'b000, 32'h40000000, 4'b0000, 2, 1);
    run_vec("shift23",  1'b0, 8'h85, 24'h000001, 1'b0, 3'b000, 32'h37000000, 4'b0000, 25, 5);
    run_vec("tie_odd",  1'b0, 8'h7F, 24'h800001, 1'b0, 3'b100, 32'h3F800002, 4'b0010, 2, 0);
    run_vec("tie_even", 1'b0, 8'h7F, 24'h800000, 1'b0, 3'b100, 32'h3F800000, 4'b0010, 2, 0);
    run_vec("rnd_ovf",  1'b0, 8'hFE, 24'hFFFFFF, 1'b0, 3'b110, 32'h7F800000, 4'b1010, 2, 0);
    run_vec("zero",     1'b1, 8'h40, 24'h000000, 1'b0, 3'b000, 32'h80000000, 4'b0001, 2, 0);
    run_vec("denorm",   1'b0, 8'h01, 24'h400000, 1'b0, 3'b100, 32'h00400000, 4'b0110, 2, 0);
    run_vec("floor",    1'b0, 8'h03, 24'h100000, 1'b0, 3'b000, 32'h00400000, 4'b0000, 4, 0);
    run_vec("cout_ovf", 1'b0, 8'hFE, 24'h000000, 1'b1, 3'b000, 32'h7F800000, 4'b1010, 2, 0);

    // Reset in the middle of a long normalisation
    @(negedge clk);
    in_sign  = 1'b0;
    in_exp   = 8'h85;
    in_mant  = 24'h000001;
    in_cout  = 1'b0;
    in_grs   = 3'b000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst in_ready", 32'(in_ready), 32'd1);
    run_vec("after_rst", 1'b0, 8'h7F, 24'h800000, 1'b0, 3'b000, 32'h3F800000, 4'b0000, 2, 0);

    for (int n = 0; n < 60; n++) begin
      r_s   = 1'($urandom_range(0, 1));
      r_c   = ($urandom_range(0, 3) == 0);
      r_grs = 3'($urandom_range(0, 7));
      r_m   = 24'($urandom()) >> $urandom_range(0, 24);
      case ($urandom_range(0, 4))
        0:       r_e = 8'($urandom_range(1, 4));
        1:       begin r_e = 8'hFE; r_m = 24'hFFFFFF; end
        default: r_e = 8'($urandom_range(1, 254));
      endcase
      fp_model(r_s, r_e, r_m, r_c, r_grs, m_res, m_flg, m_k);
      run_vec("rand", r_s, r_e, r_m, r_c, r_grs, m_res, m_flg, 2 + m_k,
              int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
